counter_bank: RTL and testbench
===============================

COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent counter channels (1..8).
REQ-002 Parameter WIDTH, default 64, counter width per channel; only 32 or 64 SHALL be legal.
REQ-003 Port clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 Port resetn  input  1  asynchronous, active-low reset.
REQ-005 Port incr  input  CHANNELS  per-channel increment strobe.
REQ-006 Port inhibit  input  CHANNELS  per-channel freeze; when high, incr is ignored.
REQ-007 Port wr_en  input  1  write strobe, one register per cycle.
REQ-008 Port wr_sel  input  max(1,clog2(CHANNELS))  target channel; out-of-range values SHALL make the write a no-op.
REQ-009 Port wr_cmp  input  1  0 = write count register, 1 = write compare register.
REQ-010 Port wr_hi  input  1  0 = bits [31:0], 1 = bits [63:32]; ignored when WIDTH=32.
REQ-011 Port wr_data  input  32  write data.
REQ-012 Port count  output  CHANNELS*WIDTH  concatenated count registers, channel 0 in LSBs.
REQ-013 Port match  output  CHANNELS  sticky compare-reached flags.
REQ-014 Port overflow  output  CHANNELS  sticky wrap flags.

Function
REQ-015 Each channel count SHALL increment by exactly 1 per cycle where incr[i]=1, inhibit[i]=0 and no count write targets channel i.
REQ-016 Increment from all-ones SHALL wrap to 0 and set overflow[i] at the same edge.
REQ-017 A count write SHALL replace only the selected 32-bit half; the other half SHALL hold its current value (no increment that cycle).
REQ-018 A count write SHALL clear overflow[i]; a simultaneous wrap on that channel cannot occur (write has priority, REQ-017).
REQ-019 A compare write SHALL replace only the selected 32-bit half of cmp[i]; compare registers are internal, not output.
REQ-020 match[i] SHALL be set at the edge where the pre-edge values satisfy count[i] >= cmp[i] (unsigned, full WIDTH), i.e. one cycle after count reaches cmp.
REQ-021 match[i] SHALL remain set until a compare write to channel i clears it; clear SHALL win over set in the same cycle.
REQ-022 After a compare write, match[i] SHALL re-evaluate from the following cycle using the new cmp value.
REQ-023 Writes to channel i SHALL NOT affect any other channel's count, cmp, match or overflow.
REQ-024 count output SHALL be the register value directly (zero combinational latency from state).

Reset
REQ-025 On resetn low, asynchronously: every count = 0, every cmp = all-ones, match = 0, overflow = 0.
REQ-026 Reset asserted mid-operation SHALL abandon any in-flight write or increment; first update after deassertion SHALL occur on the first rising clk edge with resetn high.
REQ-027 No output SHALL be X after reset.

Structure
REQ-028 Package counter_bank_pkg SHALL hold the write-target encoding constants (WR_COUNT, WR_CMP, WR_LO, WR_HI) and the channel-index width function.
REQ-029 One sub-module counter_channel SHALL implement count, cmp, match and overflow for a single channel; counter_bank SHALL instantiate CHANNELS of them via generate and decode wr_sel.
REQ-030 Total RTL SHALL be 120-400 lines; no vendor primitives.

Verification
REQ-031 Reset release, incr[0]=1 for 10 cycles -> count0=10, other channels 0, match=0, overflow=0.
REQ-032 Write count0 lo=0xFFFFFFFF, hi=0xFFFFFFFF, then one incr -> count0=0, overflow[0]=1; next count lo write -> overflow[0]=0.
REQ-033 cmp1=5 (lo=5, hi=0), incr[1] continuous -> match[1] rises the cycle after count1=5; cmp1 write of 100 -> match[1]=0 next cycle, stays 0 until count1>=100.
REQ-034 inhibit[2]=1 with incr[2]=1 for 8 cycles -> count2 unchanged; same-cycle count write and incr on channel 3 -> written value exactly, no +1.
REQ-035 Assert resetn low mid-count on all channels with pending write -> all outputs return to REQ-025 values immediately, without a clk edge.
REQ-036 WIDTH=32, CHANNELS=1 build: wr_hi=1 write of 0x1234 -> applied to bits [31:0]; wr_sel=1 write -> no effect.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared constants and helpers for the counter bank: write-target encodings
// and the width of the channel-select field.
package counter_bank_pkg;

    // wr_cmp encoding: which register of the selected channel is written
    localparam logic WR_COUNT = 1'b0;
    localparam logic WR_CMP   = 1'b1;

    // wr_hi encoding: which 32-bit half of the register is written
    localparam logic WR_LO    = 1'b0;
    localparam logic WR_HI    = 1'b1;

    // Channel-select width; a single-channel bank still carries a 1-bit select
    function automatic int ch_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: free-running count with freeze, a compare register,
// a sticky compare-reached flag and a sticky wrap flag.
module counter_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             i_resetn,
    input  logic             i_incr,
    input  logic             i_inhibit,
    input  logic             i_wr_en,
    input  logic             i_wr_cmp,
    input  logic             i_wr_hi,
    input  logic [31:0]      i_wr_data,
    output logic [WIDTH-1:0] o_count,
    output logic             o_match,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_cmp;
    logic             r_match;
    logic             r_overflow;

    logic             w_cnt_wr;
    logic             w_cmp_wr;
    logic             w_inc;
    logic             w_wrap;
    logic             w_reached;
    logic [WIDTH-1:0] w_cnt_merged;
    logic [WIDTH-1:0] w_cmp_merged;

    // A count write takes priority over the increment strobe
    assign w_cnt_wr  = i_wr_en && (i_wr_cmp == WR_COUNT);
    assign w_cmp_wr  = i_wr_en && (i_wr_cmp == WR_CMP);
    assign w_inc     = i_incr && !i_inhibit && !w_cnt_wr;
    assign w_wrap    = w_inc && (r_count == '1);
    assign w_reached = (r_count >= r_cmp);

    // Half-word merge: only the addressed 32 bits change, the rest hold
    generate
        if (WIDTH == 64) begin : g_w64
            assign w_cnt_merged = (i_wr_hi == WR_HI) ? {i_wr_data, r_count[31:0]}
                                                     : {r_count[63:32], i_wr_data};
            assign w_cmp_merged = (i_wr_hi == WR_HI) ? {i_wr_data, r_cmp[31:0]}
                                                     : {r_cmp[63:32], i_wr_data};
        end else begin : g_w32
            // A 32-bit channel has a single half; the half select is don't-care
            logic w_unused_hi;
            assign w_unused_hi  = i_wr_hi;
            assign w_cnt_merged = i_wr_data;
            assign w_cmp_merged = i_wr_data;
        end
    endgenerate

    // Count register: write replaces a half, otherwise step by one when enabled
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_count <= '0;
        end else if (w_cnt_wr) begin
            r_count <= w_cnt_merged;
        end else if (w_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Compare register: resets to all-ones so an idle channel never matches early
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cmp <= '1;
        end else if (w_cmp_wr) begin
            r_cmp <= w_cmp_merged;
        end
    end

    // Sticky match flag: a compare write clears it and wins over a same-cycle set
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_match <= 1'b0;
        end else if (w_cmp_wr) begin
            r_match <= 1'b0;
        end else if (w_reached) begin
            r_match <= 1'b1;
        end
    end

    // Sticky overflow flag: set on wrap, cleared by any count write
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_overflow <= 1'b0;
        end else if (w_cnt_wr) begin
            r_overflow <= 1'b0;
        end else if (w_wrap) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_match    = r_match;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent counter channels sharing one write port. The write
// select is decoded here; out-of-range selects hit no channel.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 64
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [CHANNELS-1:0]               incr,
    input  logic [CHANNELS-1:0]               inhibit,
    input  logic                              wr_en,
    input  logic [ch_idx_width(CHANNELS)-1:0] wr_sel,
    input  logic                              wr_cmp,
    input  logic                              wr_hi,
    input  logic [31:0]                       wr_data,
    output logic [CHANNELS*WIDTH-1:0]         count,
    output logic [CHANNELS-1:0]               match,
    output logic [CHANNELS-1:0]               overflow
);

    localparam int SEL_W = ch_idx_width(CHANNELS);

    logic [CHANNELS-1:0] w_wr_en;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            // Per-channel write strobe; select values beyond CHANNELS-1 never match
            assign w_wr_en[i] = wr_en && (wr_sel == SEL_W'(i));

            counter_channel #(
                .WIDTH (WIDTH)
            ) u_channel (
                .clk        (clk),
                .i_resetn   (resetn),
                .i_incr     (incr[i]),
                .i_inhibit  (inhibit[i]),
                .i_wr_en    (w_wr_en[i]),
                .i_wr_cmp   (wr_cmp),
                .i_wr_hi    (wr_hi),
                .i_wr_data  (wr_data),
                .o_count    (count[i*WIDTH +: WIDTH]),
                .o_match    (match[i]),
                .o_overflow (overflow[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: a default 4x64 bank plus a 1x32 build.
module tb_counter_bank;

    logic         clk;
    logic         resetn;

    logic [3:0]   incr;
    logic [3:0]   inhibit;
    logic         wr_en;
    logic [1:0]   wr_sel;
    logic         wr_cmp;
    logic         wr_hi;
    logic [31:0]  wr_data;
    logic [255:0] count;
    logic [3:0]   match;
    logic [3:0]   overflow;

    logic [0:0]   s_incr;
    logic [0:0]   s_inhibit;
    logic         s_wr_en;
    logic [0:0]   s_wr_sel;
    logic         s_wr_cmp;
    logic         s_wr_hi;
    logic [31:0]  s_wr_data;
    logic [31:0]  s_count;
    logic [0:0]   s_match;
    logic [0:0]   s_overflow;

    int n_vec;
    int n_err;

    counter_bank #(
        .CHANNELS (4),
        .WIDTH    (64)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .incr     (incr),
        .inhibit  (inhibit),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_cmp   (wr_cmp),
        .wr_hi    (wr_hi),
        .wr_data  (wr_data),
        .count    (count),
        .match    (match),
        .overflow (overflow)
    );

    counter_bank #(
        .CHANNELS (1),
        .WIDTH    (32)
    ) dut32 (
        .clk      (clk),
        .resetn   (resetn),
        .incr     (s_incr),
        .inhibit  (s_inhibit),
        .wr_en    (s_wr_en),
        .wr_sel   (s_wr_sel),
        .wr_cmp   (s_wr_cmp),
        .wr_hi    (s_wr_hi),
        .wr_data  (s_wr_data),
        .count    (s_count),
        .match    (s_match),
        .overflow (s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] cnt(input int ch);
        return count[ch*64 +: 64];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        incr      = '0;
        inhibit   = '0;
        wr_en     = 1'b0;
        wr_sel    = '0;
        wr_cmp    = 1'b0;
        wr_hi     = 1'b0;
        wr_data   = '0;
        s_incr    = '0;
        s_inhibit = '0;
        s_wr_en   = 1'b0;
        s_wr_sel  = '0;
        s_wr_cmp  = 1'b0;
        s_wr_hi   = 1'b0;
        s_wr_data = '0;

        // Reset state
        #3;
        check("rst_count", count, 256'd0);
        check("rst_match", match, 4'd0);
        check("rst_ovf", overflow, 4'd0);
        check("rst_s_count", s_count, 32'd0);

        @(negedge clk);
        resetn = 1'b1;

        // 32-bit build: wr_hi ignored, out-of-range select is a no-op
        s_wr_en = 1'b1; s_wr_sel = 1'b0; s_wr_cmp = 1'b0; s_wr_hi = 1'b1; s_wr_data = 32'h1234;
        cyc(1);
        check("w32_hi_write", s_count, 32'h1234);
        s_wr_sel = 1'b1; s_wr_hi = 1'b0; s_wr_data = 32'hFFFF;
        cyc(1);
        check("w32_sel_oor", s_count, 32'h1234);
        s_wr_sel = 1'b0; s_wr_data = 32'hFFFF_FFFF;
        cyc(1);
        s_wr_en = 1'b0; s_incr = 1'b1;
        cyc(1);
        s_incr = 1'b0;
        check("w32_wrap_count", s_count, 32'd0);
        check("w32_wrap_ovf", s_overflow, 1'b1);
        check("w32_match_allones", s_match, 1'b1);

        // Ten increments on channel 0
        incr = 4'b0001;
        cyc(10);
        incr = 4'b0000;
        check("inc10_count", count, 256'd10);
        check("inc10_match", match, 4'd0);
        check("inc10_ovf", overflow, 4'd0);

        // Channel 0 wrap from all-ones
        wr_en = 1'b1; wr_sel = 2'd0; wr_cmp = 1'b0; wr_hi = 1'b0; wr_data = 32'hFFFF_FFFF;
        cyc(1);
        wr_hi = 1'b1;
        cyc(1);
        wr_en = 1'b0;
        check("c0_allones", cnt(0), 64'hFFFF_FFFF_FFFF_FFFF);
        incr = 4'b0001;
        cyc(1);
        incr = 4'b0000;
        check("c0_wrap_count", cnt(0), 64'd0);
        check("c0_wrap_ovf", overflow, 4'b0001);
        check("c0_match_allones", match, 4'b0001);
        wr_en = 1'b1; wr_hi = 1'b0; wr_data = 32'd7;
        cyc(1);
        wr_en = 1'b0;
        check("c0_ovf_clear", overflow, 4'b0000);
        check("c0_lo_write", cnt(0), 64'd7);

        // Channel 1 compare at 5, then retarget to 100 while counting
        wr_en = 1'b1; wr_sel = 2'd1; wr_cmp = 1'b1; wr_hi = 1'b0; wr_data = 32'd5;
        cyc(1);
        wr_hi = 1'b1; wr_data = 32'd0;
        cyc(1);
        wr_en = 1'b0;
        incr = 4'b0010;
        cyc(5);
        check("c1_at5_count", cnt(1), 64'd5);
        check("c1_at5_match", match, 4'b0001);
        cyc(1);
        check("c1_match_rise", match, 4'b0011);
        wr_en = 1'b1; wr_hi = 1'b0; wr_data = 32'd100;
        cyc(1);
        wr_en = 1'b0;
        check("c1_cmp_clear", match, 4'b0001);
        check("c1_count_7", cnt(1), 64'd7);
        cyc(93);
        check("c1_at100_count", cnt(1), 64'd100);
        check("c1_at100_match", match, 4'b0001);
        cyc(1);
        check("c1_match_100", match, 4'b0011);
        incr = 4'b0000;

        // Channel 2 frozen by inhibit
        inhibit = 4'b0100; incr = 4'b0100;
        cyc(8);
        inhibit = 4'b0000; incr = 4'b0000;
        check("c2_inhibit", cnt(2), 64'd0);

        // Channel 3 write beats a same-cycle increment, both halves
        wr_en = 1'b1; wr_sel = 2'd3; wr_cmp = 1'b0; wr_hi = 1'b0; wr_data = 32'h55;
        incr = 4'b1000;
        cyc(1);
        check("c3_wr_lo_no_inc", cnt(3), 64'h55);
        wr_hi = 1'b1; wr_data = 32'hA;
        cyc(1);
        wr_en = 1'b0; incr = 4'b0000;
        check("c3_wr_hi_no_inc", cnt(3), 64'h0000_000A_0000_0055);
        check("c3_ovf_isolated", overflow, 4'b0000);

        // Asynchronous reset mid-operation with a pending write
        incr = 4'hF;
        wr_en = 1'b1; wr_sel = 2'd2; wr_cmp = 1'b0; wr_hi = 1'b0; wr_data = 32'h99;
        #2;
        resetn = 1'b0;
        #1;
        check("arst_count", count, 256'd0);
        check("arst_match", match, 4'd0);
        check("arst_ovf", overflow, 4'd0);
        check("arst_s_count", s_count, 32'd0);
        check("arst_s_flags", {s_match, s_overflow}, 2'b00);

        @(negedge clk);
        resetn = 1'b1;
        wr_en = 1'b0;
        incr = 4'b0001;
        cyc(1);
        incr = 4'b0000;
        check("post_rst_count", count, 256'd1);
        check("post_rst_match", match, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
